// File: rtl/sha256_req_arbiter.sv
// Round-robin arbiter sharing one sha256_core between NUM_REQ requesters.
// A watchdog turns a hung core into an error response.
module sha256_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*512-1:0] req_data,
    input  logic [NUM_REQ*32-1:0]  req_len,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [255:0]           resp_hash,
    output logic                   resp_err,
    output logic                   core_start,
    output logic [511:0]           core_data,
    output logic [31:0]            core_length,
    input  logic [255:0]           core_hash,
    input  logic                   core_done,
    input  logic                   core_busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic            hit_hi;
    logic            hit_lo;
    logic            take;
    logic [511:0]    win_data;
    logic [31:0]     win_len;
    logic [WD_W-1:0] wd;

    // Wrap-around search: lowest request at/above ptr, else lowest overall.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req[j] && !hit_lo) begin
                hit_lo = 1'b1;
                win_lo = ID_W'(j);
            end
            if (req[j] && !hit_hi && (ID_W'(j) >= ptr)) begin
                hit_hi = 1'b1;
                win_hi = ID_W'(j);
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_data = '0;
        win_len  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == winner) begin
                win_data = req_data[j*512 +: 512];
                win_len  = req_len[j*32 +: 32];
            end
        end
    end

    assign take = (state == IDLE) && !rst && !core_busy && hit_lo;

    always_comb begin
        grant = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            grant[j] = take && (ID_W'(j) == winner);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            wd          <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_hash   <= '0;
            resp_err    <= 1'b0;
            core_start  <= 1'b0;
            core_data   <= '0;
            core_length <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        core_data   <= win_data;
                        core_length <= win_len;
                        resp_id     <= winner;
                        ptr         <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        core_start  <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done takes precedence over a coincident timeout
                    if (core_done) begin
                        resp_hash  <= core_hash;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        resp_hash  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Directed bench for sha256_req_arbiter; the core is modelled by driving
// core_done/core_hash directly, expected responses go through a scoreboard.
module tb_sha256_req_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [2047:0]   req_data;
    logic [127:0]    req_len;
    logic [3:0]      grant;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [255:0]    resp_hash;
    logic            resp_err;
    logic            core_start;
    logic [511:0]    core_data;
    logic [31:0]     core_length;
    logic [255:0]    core_hash;
    logic            core_done;
    logic            core_busy;

    typedef struct {
        logic [1:0]   id;
        logic [255:0] hash;
        logic         err;
    } resp_t;

    resp_t sb[$];
    int    total = 0;
    int    bad   = 0;

    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC_BLOCK = {24'h616263, 8'h80, 416'h0, 64'h18};

    sha256_req_arbiter #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_len     (req_len),
        .grant       (grant),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_hash   (resp_hash),
        .resp_err    (resp_err),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_length (core_length),
        .core_hash   (core_hash),
        .core_done   (core_done),
        .core_busy   (core_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] dat(input int i);
        return {16{32'h1000_0000 + 32'(i)}};
    endfunction

    function automatic logic [255:0] hsh(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_resp(input logic [1:0] id, input logic [255:0] h, input logic e);
        resp_t r;
        r.id   = id;
        r.hash = h;
        r.err  = e;
        sb.push_back(r);
    endtask

    task automatic pop_check(input string tag);
        resp_t r;
        check({tag, "_valid"}, resp_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, sb.size(), 1);
        end else begin
            r = sb.pop_front();
            check({tag, "_id"}, resp_id, r.id);
            check({tag, "_hash"}, resp_hash, r.hash);
            check({tag, "_err"}, resp_err, r.err);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        core_done  = 1'b0;
        core_busy  = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] eg;
        int         eid;

        core_hash = '0;
        req_len   = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*512 +: 512] = dat(i);
            req_len[i*32 +: 32]    = 32'd64 + 32'(i);
        end
        do_reset();

        check("rst_grant", grant, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_hash", resp_hash, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_data", core_data, 0);
        check("rst_core_length", core_length, 0);

        // single "abc" request from requester 1
        req_data[511:0]    = dat(0);
        req_data[1*512 +: 512] = ABC_BLOCK;
        req_len[1*32 +: 32]    = 32'd3;
        req = 4'b0010;
        #1;
        check("t1_grant", grant, 4'b0010);
        tick();
        req = '0;
        check("t1_start", core_start, 1);
        check("t1_data", core_data, ABC_BLOCK);
        check("t1_len", core_length, 32'd3);
        tick();
        check("t1_start_pulse", core_start, 0);
        core_done = 1'b1;
        core_hash = ABC_HASH;
        push_resp(2'd1, ABC_HASH, 1'b0);
        tick();
        core_done = 1'b0;
        core_hash = '1;
        pop_check("t1_resp");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t1_valid_drop", resp_valid, 0);
        req_data[1*512 +: 512] = dat(1);
        req_len[1*32 +: 32]    = 32'd65;

        // round-robin with all requesters active
        do_reset();
        req        = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int n = 0; n < 8; n++) begin
            eid = n % 4;
            eg  = 4'b0001 << eid;
            check("rr_grant", grant, eg);
            check("rr_onehot", $onehot0(grant), 1);
            tick();
            check("rr_start", core_start, 1);
            check("rr_core_data", core_data, dat(eid));
            check("rr_no_grant_issue", grant, 0);
            tick();
            check("rr_no_grant_wait", grant, 0);
            core_done = 1'b1;
            core_hash = hsh(eid);
            push_resp(2'(eid), hsh(eid), 1'b0);
            tick();
            core_done = 1'b0;
            core_hash = '1;
            pop_check("rr_resp");
            check("rr_no_grant_resp", grant, 0);
            tick();
        end
        req        = '0;
        resp_ready = 1'b0;

        // backpressure: response held while requester 2 waits
        req = 4'b0001;
        #1;
        check("bp_grant", grant, 4'b0001);
        tick();
        req = '0;
        tick();
        core_done = 1'b1;
        core_hash = hsh(0);
        push_resp(2'd0, hsh(0), 1'b0);
        tick();
        core_done = 1'b0;
        core_hash = '1;
        req       = 4'b0100;
        #1;
        for (int k = 0; k < 20; k++) begin
            check("bp_valid", resp_valid, 1);
            check("bp_hash", resp_hash, hsh(0));
            check("bp_no_grant", grant, 0);
            check("bp_no_start", core_start, 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        pop_check("bp_resp");
        check("bp_no_grant_handshake", grant, 0);
        tick();
        resp_ready = 1'b0;
        #1;
        check("bp_valid_drop", resp_valid, 0);
        check("bp_next_grant", grant, 4'b0100);
        tick();
        req = '0;
        check("bp_next_start", core_start, 1);
        check("bp_next_id", resp_id, 2);

        // watchdog timeout, then done coinciding with timeout
        do_reset();
        req = 4'b0001;
        #1;
        check("to_grant", grant, 4'b0001);
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 15; k++) tick();
        check("to_not_yet", resp_valid, 0);
        push_resp(2'd0, 256'h0, 1'b1);
        tick();
        pop_check("to_resp");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req = 4'b0010;
        #1;
        check("tc_grant", grant, 4'b0010);
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 15; k++) tick();
        check("tc_not_yet", resp_valid, 0);
        core_done = 1'b1;
        core_hash = hsh(1);
        push_resp(2'd1, hsh(1), 1'b0);
        tick();
        core_done = 1'b0;
        pop_check("tc_resp");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // reset while waiting on the core
        req = 4'b0100;
        #1;
        check("rm_grant", grant, 4'b0100);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rm_grant_zero", grant, 0);
        check("rm_valid", resp_valid, 0);
        check("rm_id", resp_id, 0);
        check("rm_hash", resp_hash, 0);
        check("rm_err", resp_err, 0);
        check("rm_start", core_start, 0);
        check("rm_data", core_data, 0);
        check("rm_len", core_length, 0);
        rst       = 1'b0;
        core_done = 1'b1;
        core_hash = hsh(3);
        tick();
        core_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rm_late_done", resp_valid, 0);
            tick();
        end
        req = 4'b1111;
        #1;
        check("rm_ptr_restart", grant, 4'b0001);

        // core busy blocks grants; zero length and data stability
        do_reset();
        req_len[31:0] = 32'd0;
        core_busy     = 1'b1;
        req           = 4'b0001;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("cb_no_grant", grant, 0);
            tick();
            check("cb_no_start", core_start, 0);
        end
        core_busy = 1'b0;
        #1;
        check("cb_grant", grant, 4'b0001);
        tick();
        req              = '0;
        req_data[511:0]  = ~dat(0);
        req_len[31:0]    = 32'd77;
        check("cb_start", core_start, 1);
        check("cb_zero_len", core_length, 0);
        check("cb_data", core_data, dat(0));
        tick();
        check("cb_data_stable", core_data, dat(0));
        check("cb_len_stable", core_length, 0);
        check("cb_start_pulse", core_start, 0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_req_arbiter.md
Name: sha256_req_arbiter

Overview:
- Shares one sha256_core instance between NUM_REQ requesters, for example the HMAC inner/outer passes and other hash users.
- Arbitrates round-robin and latches the winner's block and length.
- Sequences the core through start/done and returns the digest to the winner, tagged with its ID.
- A watchdog converts a hung core into an error response, so a requester never waits forever.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- TIMEOUT, 1024, maximum cycles in WAIT before an error response; must be at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held high until granted.
- req_data  in  NUM_REQ*512  request block; requester i uses bits [i*512 +: 512].
- req_len  in  NUM_REQ*32  request length in bytes; requester i uses bits [i*32 +: 32].
- grant  out  NUM_REQ  one-hot, one-cycle pulse; the request is accepted this cycle.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester being answered.
- resp_hash  out  256  digest.
- resp_err  out  1  the response is a timeout, not a hash.
- core_start  out  1  one-cycle start pulse to sha256_core.
- core_data  out  512  latched block to the core.
- core_length  out  32  latched length to the core.
- core_hash  in  256  digest from the core.
- core_done  in  1  core completion pulse.
- core_busy  in  1  core busy.

Behaviour:
- Reset values: state=IDLE, grant=0, resp_valid=0, resp_id=0, resp_hash=0, resp_err=0, core_start=0, core_data=0, core_length=0, priority pointer=0, watchdog=0. Reset takes effect on the next edge from any state; an in-flight core job is abandoned and its late core_done is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, entry condition: taken when |req and core_busy=0.
- IDLE, winner selection: the winner is the first asserted req at or after the pointer, searching upward with wrap-around from NUM_REQ-1 to 0.
- IDLE, actions in the same cycle:
  - grant[winner]=1.
  - Latch req_data, req_len and the winner ID into core_data, core_length and resp_id.
  - pointer <= (winner+1) mod NUM_REQ.
  - Go to ISSUE.
- IDLE, core busy: if core_busy=1, stay in IDLE and issue no grant.
- ISSUE: core_start=1 for exactly one cycle; clear the watchdog; go to WAIT.
- WAIT, done: on core_done, latch resp_hash<=core_hash and resp_err<=0; go to RESP. Every pulse of core_done in WAIT is honoured, so no done is lost.
- WAIT, timeout: the watchdog increments each cycle. When it equals TIMEOUT-1 and core_done=0: resp_hash<=0, resp_err<=1, go to RESP.
- WAIT, simultaneous events: if core_done and the timeout occur in the same cycle, core_done wins and resp_err=0.
- RESP:
  - resp_valid=1, with resp_id, resp_hash and resp_err held stable until resp_ready=1.
  - On the handshake edge, drop resp_valid and go to IDLE.
  - The next grant comes at the earliest one cycle later, so there is no back-to-back grant in the same cycle as the handshake.
- Latency: from req rising in IDLE, grant comes the same cycle and core_start the next cycle. resp_valid comes 1 cycle after the core_done edge.
- Concurrency: only one job is outstanding. grant never asserts outside IDLE, and grant is always zero- or one-hot.
- Fairness: each requester that holds req is granted within NUM_REQ grants.
- Request stability: req_data and req_len are sampled only in the grant cycle; later changes have no effect on the job.
- Zero length: req_len=0 is passed through unchanged; the arbiter does not validate lengths.

Test Plan:
1. Single request: reset, then req=4'b0010, len=3, data="abc" padded. Expect grant=4'b0010 in that cycle, core_start one cycle later, and after the core's done resp_valid=1, resp_id=1, resp_hash=ba7816bf...f20015ad, resp_err=0.
2. Round-robin: hold req=4'b1111 for 8 jobs with resp_ready=1. Expect grant order 0,1,2,3,0,1,2,3, and never two bits high.
3. Backpressure: hold resp_ready=0 for 20 cycles in RESP while another req is high. Expect resp_valid and resp_hash stable, no grant, and no core_start until resp_ready=1.
4. Timeout: with TIMEOUT=16, a core stub that never pulses done. Expect resp_valid 16 cycles after WAIT entry, with resp_err=1 and resp_hash=0. Then done arriving in the same cycle as the timeout gives resp_err=0.
5. Reset mid-job: assert rst during WAIT. Expect all outputs zero on the next edge; a late core_done produces no response; the pointer restarts at 0.
6. Core busy: hold core_busy=1 with req=4'b0001. Expect no grant; the grant comes the first cycle core_busy=0.
